fsm_op_sequencer: RTL and testbench
===================================

# fsm_op_sequencer

- Command-level controller that sequences one instance of the nibble-serial FSM datapath (`fsm_design`, N=64, N_width=4).
- Accepts one command per job: full-width operands plus a short opcode program.
- Executes the job on the datapath:
  - pulses start, then streams operand nibbles in;
  - plays the opcode program on `op_val`, then steers the FSM to OUTPUT;
  - collects the result nibbles and returns the assembled N-bit result over a valid/ready handshake.
- Sits between the chip pin/host layer and the datapath and owns every datapath control input.

## Interface
- `N`, 64: operand/result width.
- `N_width`, 4: datapath nibble width. K = N/N_width = 16 transfers per direction.
- `PROG_DEPTH`, 8: maximum opcodes per command.
- `WD_LIMIT`, 15: watchdog limit in cycles.

Ports:
- `clk`  in  1  the one clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_a`, `cmd_b`  in  N  operands.
- `cmd_prog`  in  2*PROG_DEPTH  opcodes; entry i is `[2i+1:2i]`.
- `cmd_len`  in  $clog2(PROG_DEPTH)+1  opcode count.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_data`  out  N  assembled result.
- `busy`  out  1  state != IDLE.
- `error`  out  1  sticky fault flag.
- `dp_start`, `dp_input_enable`  out  1  datapath controls.
- `dp_a`, `dp_b`  out  N_width  operand nibbles.
- `dp_op_val`  out  2  datapath opcode.
- `dp_state`  in  4  datapath state code: S0..S7=0..7, IDLE=8, INPUT=9, OUTPUT=10.
- `dp_output_valid`  in  1  datapath result nibble valid.
- `dp_out`  in  N_width  datapath result nibble.

## Operation

States: IDLE, START, LOAD, RUN, DRAIN, COLLECT, DONE, ERR.

- **IDLE**
  - `cmd_ready`=1.
  - On accept: latch a, b, prog; latch len clamped to PROG_DEPTH; clear `error`; go to START.
- **START**
  - `dp_start`=1.
  - If `dp_state`==IDLE this cycle, go to LOAD; the datapath enters INPUT on the same edge.
  - Otherwise stay in START.
- **LOAD**
  - `dp_input_enable`=1.
  - `dp_a`/`dp_b` = latched operand nibble `[i*N_width +: N_width]`, with i = 0..K-1, one per cycle, LSB nibble first.
  - After i=K-1, go to RUN, or to DRAIN if len=0.
  - If `dp_state`!=INPUT in any LOAD cycle, go to ERR.
- **RUN**
  - `dp_op_val`=prog[pc], with pc = 0..len-1, one per cycle.
  - After pc=len-1, go to DRAIN.
  - If `dp_state[3]`=1, go to ERR.
- **DRAIN**
  - `dp_op_val` comes combinationally from `dp_state`: S0,S1,S2,S3→2; S4→1; S5,S6,S7→0.
  - This is the shortest path to OUTPUT, at most 5 cycles (from S3).
  - On first `dp_output_valid`=1: capture nibble 0 and go to COLLECT.
- **COLLECT**
  - Each cycle with `dp_output_valid`=1: `res_data[j*N_width +: N_width]` <= `dp_out`, j++.
  - After j=K-1 is captured, go to DONE.
  - If `dp_output_valid`=0 in COLLECT, go to ERR.
- **DONE**
  - `res_valid`=1; `res_data` stays stable.
  - On `res_ready`, go to IDLE.
- **ERR**
  - Sets `error`=1 (sticky until the next command is accepted).
  - Next cycle goes to IDLE; `res_data` keeps its last value.
- **Watchdog**
  - The counter increments in START and DRAIN and clears on every state change.
  - When it reaches `WD_LIMIT`, go to ERR.
- **Default drive**
  - `dp_start`, `dp_input_enable`, `dp_a`, `dp_b`, `dp_op_val` are all 0 outside the states that drive them.
  - The datapath ignores `op_val` in IDLE, INPUT and OUTPUT.

Note: every RUN and DRAIN cycle updates the datapath accumulator, so drain steps are part of the computed result.

## Timing
- **Reset** (sampled at a `clk` edge):
  - State → IDLE; all outputs 0, including `res_data` and `error`.
  - `cmd_ready` goes to 1 in the first cycle after `rst` deasserts.
  - A reset mid-job does not reset the datapath. The next job then waits in START and trips the watchdog unless the datapath has returned to IDLE.
- **Latency.** Let cycle 0 be the accept cycle and d the number of DRAIN cycles before OUTPUT.
  - `res_valid` first high in cycle 2 + 2K + len + d.
  - This holds when the datapath is in IDLE at START.
- **Throughput.** One job in flight. `cmd_ready`=0 from the accept edge until DONE completes its handshake.
- **Result handshake.** Transfer occurs on `res_valid`&`res_ready`. `res_valid` may be held indefinitely with `res_data` stable.

## Test plan
1. **Empty program.** a=5, b=3, len=0, datapath IDLE.
   - Drain path S0(op2)→S4(op1)→OUTPUT, d=2.
   - `res_data`=7, `res_valid` in cycle 36, `error`=0.
2. **One opcode.** len=1, prog[0]=3, a=5, b=3.
   - Path S0→S1→S5→S4→OUTPUT.
   - `res_data`=5, `res_valid` in cycle 38.
3. **Length clamp.** len=9, all opcodes 1, a=5, b=3.
   - Exactly 8 RUN cycles, datapath stays in S0.
   - `res_data`=7, `res_valid` in cycle 44.
4. **Backpressure.** Hold `res_ready`=0 for 10 cycles after `res_valid`.
   - `res_data` stable, `cmd_ready`=0, `busy`=1.
   - After `res_ready`=1: IDLE next cycle, `cmd_ready`=1.
5. **Watchdog.** Datapath model holds `dp_state`=S3 when a command is accepted.
   - After 15 START cycles: ERR, `error`=1, then IDLE with `cmd_ready`=1.
   - The next accepted command clears `error`.
6. **Reset mid-job.** Assert `rst` for one cycle during LOAD.
   - Next cycle: `busy`=0, `res_valid`=0, `error`=0, all `dp_*` outputs 0.

Source files
------------

// File: rtl/fsm_op_sequencer.sv
// Command-level sequencer for one nibble-serial fsm_design datapath: loads operands,
// plays an opcode program, steers the FSM to OUTPUT and returns the assembled result.
module fsm_op_sequencer #(
   parameter int N          = 64,
   parameter int N_width    = 4,
   parameter int PROG_DEPTH = 8,
   parameter int WD_LIMIT   = 15
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          cmd_valid_i,
   output logic                          cmd_ready_o,
   input  logic [N-1:0]                  cmd_a_i,
   input  logic [N-1:0]                  cmd_b_i,
   input  logic [2*PROG_DEPTH-1:0]       cmd_prog_i,
   input  logic [$clog2(PROG_DEPTH):0]   cmd_len_i,
   output logic                          res_valid_o,
   input  logic                          res_ready_i,
   output logic [N-1:0]                  res_data_o,
   output logic                          busy_o,
   output logic                          error_o,
   output logic                          dp_start_o,
   output logic                          dp_input_enable_o,
   output logic [N_width-1:0]            dp_a_o,
   output logic [N_width-1:0]            dp_b_o,
   output logic [1:0]                    dp_op_val_o,
   input  logic [3:0]                    dp_state_i,
   input  logic                          dp_output_valid_i,
   input  logic [N_width-1:0]            dp_out_i
);

   localparam int K   = N / N_width;
   localparam int LW  = $clog2(PROG_DEPTH) + 1;
   localparam int IW  = (K > 1) ? $clog2(K) : 1;
   localparam int WDW = $clog2(WD_LIMIT + 1);

   localparam logic [3:0] DP_IDLE   = 4'd8;
   localparam logic [3:0] DP_INPUT  = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_LOAD, S_RUN, S_DRAIN, S_COLLECT, S_DONE, S_ERR
   } state_t;

   typedef struct packed {
      logic [N-1:0]            a;
      logic [N-1:0]            b;
      logic [2*PROG_DEPTH-1:0] prog;
      logic [LW-1:0]           len;
   } cmd_t;

   state_t         state_q, state_d;
   cmd_t           cmd_q, cmd_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [LW-1:0]  pc_q, pc_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic [N-1:0]   res_q, res_d;
   logic           err_q, err_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         idx_q   <= '0;
         pc_q    <= '0;
         wd_q    <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         idx_q   <= idx_d;
         pc_q    <= pc_d;
         wd_q    <= wd_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      cmd_d             = cmd_q;
      idx_d             = idx_q;
      pc_d              = pc_q;
      wd_d              = '0;
      res_d             = res_q;
      err_d             = err_q;
      cmd_ready_o       = 1'b0;
      res_valid_o       = 1'b0;
      dp_start_o        = 1'b0;
      dp_input_enable_o = 1'b0;
      dp_a_o            = '0;
      dp_b_o            = '0;
      dp_op_val_o       = 2'd0;

      case (state_q)
         S_IDLE: begin
            cmd_ready_o = !rst_i;
            if (cmd_valid_i && !rst_i) begin
               cmd_d.a    = cmd_a_i;
               cmd_d.b    = cmd_b_i;
               cmd_d.prog = cmd_prog_i;
               cmd_d.len  = (cmd_len_i > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : cmd_len_i;
               err_d      = 1'b0;
               state_d    = S_START;
            end
         end
         S_START: begin
            dp_start_o = 1'b1;
            if (dp_state_i == DP_IDLE) begin
               idx_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            dp_input_enable_o = 1'b1;
            dp_a_o            = cmd_q.a[idx_q*N_width +: N_width];
            dp_b_o            = cmd_q.b[idx_q*N_width +: N_width];
            if (dp_state_i != DP_INPUT) begin
               state_d = S_ERR;
            end else if (idx_q == IW'(K-1)) begin
               pc_d    = '0;
               state_d = (cmd_q.len == '0) ? S_DRAIN : S_RUN;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_RUN: begin
            dp_op_val_o = cmd_q.prog[pc_q*2 +: 2];
            if (dp_state_i[3]) begin
               state_d = S_ERR;
            end else if (pc_q == cmd_q.len - LW'(1)) begin
               state_d = S_DRAIN;
            end else begin
               pc_d = pc_q + LW'(1);
            end
         end
         S_DRAIN: begin
            // Shortest route to OUTPUT: S0-S3 hop up, S7-S5 step down to S4, S4 exits.
            case (dp_state_i)
               4'd0, 4'd1, 4'd2, 4'd3: dp_op_val_o = 2'd2;
               4'd4:                   dp_op_val_o = 2'd1;
               default:                dp_op_val_o = 2'd0;
            endcase
            if (dp_output_valid_i) begin
               res_d[N_width-1:0] = dp_out_i;
               idx_d              = IW'(1);
               state_d            = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (!dp_output_valid_i) begin
               state_d = S_ERR;
            end else begin
               res_d[idx_q*N_width +: N_width] = dp_out_i;
               if (idx_q == IW'(K-1)) state_d = S_DONE;
               else                   idx_d   = idx_q + IW'(1);
            end
         end
         S_DONE: begin
            res_valid_o = 1'b1;
            if (res_ready_i) state_d = S_IDLE;
         end
         S_ERR: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Watchdog only runs while waiting on the datapath and restarts on any state change.
      if ((state_q == S_START || state_q == S_DRAIN) && state_d == state_q) begin
         if (wd_q == WDW'(WD_LIMIT-1)) state_d = S_ERR;
         else                          wd_d    = wd_q + WDW'(1);
      end

      if (state_d == S_ERR) err_d = 1'b1;
   end

   assign busy_o     = (state_q != S_IDLE);
   assign error_o    = err_q;
   assign res_data_o = res_q;

endmodule

// File: tb/tb_fsm_op_sequencer.sv
// Directed bench for fsm_op_sequencer with a behavioural stand-in for the nibble-serial datapath.
module tb_fsm_op_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [63:0] cmd_a, cmd_b;
   logic [15:0] cmd_prog;
   logic [3:0]  cmd_len;
   logic        res_valid, res_ready;
   logic [63:0] res_data;
   logic        busy, error;
   logic        dp_start, dp_input_enable;
   logic [3:0]  dp_a, dp_b;
   logic [1:0]  dp_op_val;
   logic [3:0]  dp_state;
   logic        dp_output_valid;
   logic [3:0]  dp_out;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fsm_op_sequencer dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_prog_i(cmd_prog), .cmd_len_i(cmd_len),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
      .busy_o(busy), .error_o(error),
      .dp_start_o(dp_start), .dp_input_enable_o(dp_input_enable),
      .dp_a_o(dp_a), .dp_b_o(dp_b), .dp_op_val_o(dp_op_val),
      .dp_state_i(dp_state), .dp_output_valid_i(dp_output_valid), .dp_out_i(dp_out)
   );

   // Datapath model: op0 acc&=a (S5-S7 step down), op1 acc|=a (S4 -> OUTPUT),
   // op2 acc|=b (S0-S3 hop +4), op3 acc^=a (Sk -> Sk+1).
   logic [3:0]  dps;
   logic [63:0] acc, ma, mb;
   int          in_cnt, out_cnt;
   logic        stuck, mdl_rst;

   assign dp_state        = dps;
   assign dp_output_valid = (dps == 4'd10);
   assign dp_out          = acc[out_cnt*4 +: 4];

   always @(posedge clk) begin
      if (mdl_rst) begin
         dps <= 4'd8; acc <= '0; in_cnt <= 0; out_cnt <= 0;
      end else if (stuck) begin
         dps <= 4'd3;
      end else if (dps == 4'd8) begin
         if (dp_start) begin dps <= 4'd9; in_cnt <= 0; acc <= '0; end
      end else if (dps == 4'd9) begin
         if (dp_input_enable) begin
            ma[in_cnt*4 +: 4] <= dp_a;
            mb[in_cnt*4 +: 4] <= dp_b;
            in_cnt <= in_cnt + 1;
            if (in_cnt == 15) dps <= 4'd0;
         end
      end else if (dps == 4'd10) begin
         out_cnt <= out_cnt + 1;
         if (out_cnt == 15) begin dps <= 4'd8; out_cnt <= 0; end
      end else begin
         case (dp_op_val)
            2'd0: begin acc <= acc & ma; if (dps > 4'd4) dps <= dps - 4'd1; end
            2'd1: begin acc <= acc | ma; if (dps == 4'd4) begin dps <= 4'd10; out_cnt <= 0; end end
            2'd2: begin acc <= acc | mb; if (dps < 4'd4) dps <= dps + 4'd4; end
            default: begin acc <= acc ^ ma; dps <= {1'b0, 3'(dps[2:0] + 3'd1)}; end
         endcase
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Offers a command in the current cycle (cycle 0) and advances to cycle 1.
   task automatic issue(input logic [63:0] a, input logic [63:0] b,
                        input logic [15:0] prog, input logic [3:0] len);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_prog = prog; cmd_len = len;
      step();
      cmd_valid = 1'b0;
   endtask

   // Called in cycle 1; returns the cycle index in which res_valid is first seen, or -1.
   task automatic wait_result(output int cyc);
      cyc = 1;
      while (!res_valid && cyc < 300) begin step(); cyc++; end
      if (!res_valid) cyc = -1;
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; mdl_rst = 1'b1;
      step(); step();
      n_chk++; if (cmd_ready !== 1'b0) $display("FAIL reset cmd_ready got %b want 0", cmd_ready); else n_pass++;
      n_chk++; if (busy !== 1'b0 || res_valid !== 1'b0 || error !== 1'b0)
         $display("FAIL reset flags busy=%b res_valid=%b error=%b want 0", busy, res_valid, error); else n_pass++;
      n_chk++; if (res_data !== 64'd0) $display("FAIL reset res_data got %h want 0", res_data); else n_pass++;
      n_chk++; if ({dp_start, dp_input_enable, dp_a, dp_b, dp_op_val} !== 11'd0)
         $display("FAIL reset dp_outputs got %b want 0", {dp_start, dp_input_enable, dp_a, dp_b, dp_op_val}); else n_pass++;
      rst = 1'b0; mdl_rst = 1'b0;
      #1;
      n_chk++; if (cmd_ready !== 1'b1) $display("FAIL reset_release cmd_ready got %b want 1", cmd_ready); else n_pass++;
   endtask

   task automatic test_empty_prog();
      int cyc;
      issue(64'd5, 64'd3, 16'h0000, 4'd0);
      n_chk++; if (cmd_ready !== 1'b0 || busy !== 1'b1)
         $display("FAIL empty_inflight cmd_ready=%b busy=%b want 0/1", cmd_ready, busy); else n_pass++;
      wait_result(cyc);
      n_chk++; if (cyc !== 36) $display("FAIL empty_latency got %0d want 36", cyc); else n_pass++;
      n_chk++; if (res_data !== 64'd7) $display("FAIL empty_result got %h want 7", res_data); else n_pass++;
      n_chk++; if (error !== 1'b0) $display("FAIL empty_error got %b want 0", error); else n_pass++;
      handshake();
   endtask

   task automatic test_one_op();
      int cyc;
      issue(64'd5, 64'd3, 16'h0003, 4'd1);
      wait_result(cyc);
      n_chk++; if (cyc !== 38) $display("FAIL one_op_latency got %0d want 38", cyc); else n_pass++;
      n_chk++; if (res_data !== 64'd5) $display("FAIL one_op_result got %h want 5", res_data); else n_pass++;
      handshake();
   endtask

   task automatic test_len_clamp();
      int cyc;
      int runs;
      issue(64'd5, 64'd3, 16'h5555, 4'd9);
      step(); // cycle 2: first LOAD
      cyc = 2; runs = 0;
      while (!res_valid && cyc < 300) begin
         if (dp_state == 4'd0 && dp_op_val == 2'd1) runs++;
         step(); cyc++;
      end
      n_chk++; if (runs !== 8) $display("FAIL clamp_run_cycles got %0d want 8", runs); else n_pass++;
      n_chk++; if (cyc !== 44) $display("FAIL clamp_latency got %0d want 44", cyc); else n_pass++;
      n_chk++; if (res_data !== 64'd7) $display("FAIL clamp_result got %h want 7", res_data); else n_pass++;
      handshake();
   endtask

   task automatic test_back_to_back();
      int cyc;
      issue(64'h0123_4567_89AB_CDEF, 64'd0, 16'h0000, 4'd0);
      wait_result(cyc);
      n_chk++; if (res_data !== 64'h0123_4567_89AB_CDEF)
         $display("FAIL b2b_a_order got %h want 0123456789abcdef", res_data); else n_pass++;
      handshake();
      n_chk++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", cmd_ready); else n_pass++;
      issue(64'd0, 64'h1122_3344_5566_7788, 16'h0000, 4'd0);
      wait_result(cyc);
      n_chk++; if (cyc !== 36) $display("FAIL b2b_latency got %0d want 36", cyc); else n_pass++;
      n_chk++; if (res_data !== 64'h1122_3344_5566_7788)
         $display("FAIL b2b_b_order got %h want 1122334455667788", res_data); else n_pass++;
      handshake();
   endtask

   task automatic test_backpressure();
      int cyc;
      issue(64'd5, 64'd3, 16'h0003, 4'd1);
      wait_result(cyc);
      for (int i = 0; i < 10; i++) begin
         step();
         n_chk++; if (res_valid !== 1'b1 || res_data !== 64'd5)
            $display("FAIL bp_hold[%0d] res_valid=%b data=%h want 1/5", i, res_valid, res_data); else n_pass++;
         n_chk++; if (cmd_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL bp_busy[%0d] cmd_ready=%b busy=%b want 0/1", i, cmd_ready, busy); else n_pass++;
      end
      handshake();
      n_chk++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0)
         $display("FAIL bp_release cmd_ready=%b busy=%b res_valid=%b want 1/0/0", cmd_ready, busy, res_valid); else n_pass++;
   endtask

   task automatic test_watchdog();
      int starts;
      int cyc;
      stuck = 1'b1;
      step();
      issue(64'd5, 64'd3, 16'h0000, 4'd0);
      starts = 0;
      while (dp_start && starts < 100) begin starts++; step(); end
      n_chk++; if (starts !== 15) $display("FAIL wd_start_cycles got %0d want 15", starts); else n_pass++;
      n_chk++; if (busy !== 1'b1 || error !== 1'b1 || cmd_ready !== 1'b0)
         $display("FAIL wd_err_state busy=%b error=%b cmd_ready=%b want 1/1/0", busy, error, cmd_ready); else n_pass++;
      step();
      n_chk++; if (busy !== 1'b0 || error !== 1'b1 || cmd_ready !== 1'b1)
         $display("FAIL wd_idle busy=%b error=%b cmd_ready=%b want 0/1/1", busy, error, cmd_ready); else n_pass++;
      stuck = 1'b0; mdl_rst = 1'b1;
      step();
      mdl_rst = 1'b0;
      n_chk++; if (error !== 1'b1) $display("FAIL wd_sticky got %b want 1", error); else n_pass++;
      issue(64'd5, 64'd3, 16'h0000, 4'd0);
      n_chk++; if (error !== 1'b0) $display("FAIL wd_clear got %b want 0", error); else n_pass++;
      wait_result(cyc);
      n_chk++; if (res_data !== 64'd7 || error !== 1'b0)
         $display("FAIL wd_recover data=%h error=%b want 7/0", res_data, error); else n_pass++;
      handshake();
   endtask

   task automatic test_reset_midjob();
      issue(64'd5, 64'd3, 16'h0000, 4'd0);
      step(); step(); step();
      n_chk++; if (dp_input_enable !== 1'b1) $display("FAIL midrst_in_load got %b want 1", dp_input_enable); else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      n_chk++; if (busy !== 1'b0 || res_valid !== 1'b0 || error !== 1'b0)
         $display("FAIL midrst_flags busy=%b res_valid=%b error=%b want 0", busy, res_valid, error); else n_pass++;
      n_chk++; if ({dp_start, dp_input_enable, dp_a, dp_b, dp_op_val} !== 11'd0)
         $display("FAIL midrst_dp got %b want 0", {dp_start, dp_input_enable, dp_a, dp_b, dp_op_val}); else n_pass++;
      n_chk++; if (cmd_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", cmd_ready); else n_pass++;
      mdl_rst = 1'b1;
      step();
      mdl_rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mdl_rst = 1'b1; stuck = 1'b0;
      cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_prog = '0; cmd_len = '0;
      res_ready = 1'b0;
      test_reset();
      test_empty_prog();
      test_one_op();
      test_len_clamp();
      test_back_to_back();
      test_backpressure();
      test_watchdog();
      test_reset_midjob();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule
